// File: rtl/pipeline_controller.sv
// Hazard and redirect sequencer: merges stage stalls, inserts load-use bubbles,
// and turns an execute-resolved branch into a PC pulse plus a timed DS/EX flush.
module pipeline_controller #(
   parameter int AWIDTH            = 5,
   parameter int PC_WIDTH          = 32,
   parameter int FLUSH_CYCLES      = 2,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CWIDTH            = 16
) (
   input  logic                hc_clk,
   input  logic                hc_rst,
   input  logic                hc_i_stall_f,
   input  logic                hc_i_stall_ds,
   input  logic                hc_i_stall_ex,
   input  logic                hc_i_stall_mem,
   input  logic                hc_i_stall_wb,
   input  logic [AWIDTH-1:0]   hc_i_ds_rs1,
   input  logic [AWIDTH-1:0]   hc_i_ds_rs2,
   input  logic                hc_i_ds_rs1_used,
   input  logic                hc_i_ds_rs2_used,
   input  logic [AWIDTH-1:0]   hc_i_ex_rd,
   input  logic                hc_i_ex_load,
   input  logic                hc_i_ex_we,
   input  logic                hc_i_change_pc,
   input  logic [PC_WIDTH-1:0] hc_i_alu_pc_value,
   output logic                hc_o_stall_f,
   output logic                hc_o_stall_ds,
   output logic                hc_o_stall_ex,
   output logic                hc_o_stall_mem,
   output logic                hc_o_stall_wb,
   output logic                hc_o_flush_ds,
   output logic                hc_o_flush_ex,
   output logic                hc_o_change_pc,
   output logic [PC_WIDTH-1:0] hc_o_pc_value,
   output logic                hc_o_busy,
   output logic [CWIDTH-1:0]   hc_o_bubble_cnt
);

   localparam int MAXC = (FLUSH_CYCLES > LOAD_STALL_CYCLES) ? FLUSH_CYCLES : LOAD_STALL_CYCLES;
   localparam int SW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {RUN = 2'd0, LSTALL = 2'd1, FLUSH = 2'd2} state_t;

   state_t                state_q;
   logic [SW-1:0]         seq_q;
   logic                  chg_q;
   logic [PC_WIDTH-1:0]   pc_q;
   logic [CWIDTH-1:0]     bub_q, bub_d;

   logic in_run, hazard, redirect_acc, lu_run, lu;

   assign in_run = (state_q == RUN);
   assign hazard = hc_i_ex_load & hc_i_ex_we & (hc_i_ex_rd != '0) &
                   ((hc_i_ds_rs1_used & (hc_i_ds_rs1 == hc_i_ex_rd)) |
                    (hc_i_ds_rs2_used & (hc_i_ds_rs2 == hc_i_ex_rd)));

   assign hc_o_stall_wb  = hc_i_stall_wb;
   assign hc_o_stall_mem = hc_i_stall_mem | hc_o_stall_wb;
   assign hc_o_stall_ex  = hc_i_stall_ex | hc_o_stall_mem;
   assign hc_o_stall_ds  = hc_i_stall_ds | hc_o_stall_ex | lu;
   assign hc_o_stall_f   = hc_i_stall_f | hc_o_stall_ds;

   // A held EX stage must not launch a redirect or a bubble; both re-evaluate once it moves.
   assign redirect_acc = in_run & hc_i_change_pc & ~hc_o_stall_ex;
   assign lu_run       = in_run & hazard & ~hc_i_change_pc & ~hc_o_stall_ex;
   assign lu           = lu_run | (state_q == LSTALL);

   assign hc_o_flush_ds   = (state_q == FLUSH);
   assign hc_o_flush_ex   = hc_o_flush_ds | lu;
   assign hc_o_change_pc  = chg_q;
   assign hc_o_pc_value   = pc_q;
   assign hc_o_busy       = ~in_run;
   assign hc_o_bubble_cnt = bub_q;

   assign bub_d = (hc_o_flush_ex && (bub_q != '1)) ? bub_q + 1'b1 : bub_q;

   always_ff @(posedge hc_clk or negedge hc_rst) begin
      if (!hc_rst) begin
         state_q <= RUN;
         seq_q   <= '0;
         chg_q   <= 1'b0;
         pc_q    <= '0;
         bub_q   <= '0;
      end else begin
         chg_q <= 1'b0;
         bub_q <= bub_d;
         case (state_q)
            RUN: begin
               if (redirect_acc) begin
                  state_q <= FLUSH;
                  seq_q   <= SW'(FLUSH_CYCLES);
                  chg_q   <= 1'b1;
                  pc_q    <= hc_i_alu_pc_value;
               end else if (lu_run && (LOAD_STALL_CYCLES > 1)) begin
                  state_q <= LSTALL;
                  seq_q   <= SW'(LOAD_STALL_CYCLES - 1);
               end
            end
            LSTALL, FLUSH: begin
               if (seq_q <= SW'(1)) begin
                  state_q <= RUN;
                  seq_q   <= '0;
               end else begin
                  seq_q <= seq_q - 1'b1;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench: u_dut (default parameters) checked through an expected-value queue;
// u_sat (CWIDTH=2, LOAD_STALL_CYCLES=2) covers multi-cycle load stall, saturation and abort.
module tb_pipeline_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   logic i_f, i_ds, i_ex, i_mem, i_wb;
   logic [4:0] rs1, rs2, ex_rd;
   logic rs1_used, rs2_used, ex_load, ex_we, change_pc;
   logic [31:0] alu_pc;

   logic a_f, a_ds, a_ex, a_mem, a_wb, a_fds, a_fex, a_cpc, a_busy;
   logic [31:0] a_pc;
   logic [15:0] a_cnt;
   logic b_f, b_ds, b_ex, b_mem, b_wb, b_fds, b_fex, b_cpc, b_busy;
   logic [31:0] b_pc;
   logic [1:0]  b_cnt;

   wire [4:0] a_st = {a_f, a_ds, a_ex, a_mem, a_wb};
   wire [4:0] b_st = {b_f, b_ds, b_ex, b_mem, b_wb};

   pipeline_controller u_dut (
      .hc_clk(clk), .hc_rst(rst_a),
      .hc_i_stall_f(i_f), .hc_i_stall_ds(i_ds), .hc_i_stall_ex(i_ex),
      .hc_i_stall_mem(i_mem), .hc_i_stall_wb(i_wb),
      .hc_i_ds_rs1(rs1), .hc_i_ds_rs2(rs2),
      .hc_i_ds_rs1_used(rs1_used), .hc_i_ds_rs2_used(rs2_used),
      .hc_i_ex_rd(ex_rd), .hc_i_ex_load(ex_load), .hc_i_ex_we(ex_we),
      .hc_i_change_pc(change_pc), .hc_i_alu_pc_value(alu_pc),
      .hc_o_stall_f(a_f), .hc_o_stall_ds(a_ds), .hc_o_stall_ex(a_ex),
      .hc_o_stall_mem(a_mem), .hc_o_stall_wb(a_wb),
      .hc_o_flush_ds(a_fds), .hc_o_flush_ex(a_fex),
      .hc_o_change_pc(a_cpc), .hc_o_pc_value(a_pc),
      .hc_o_busy(a_busy), .hc_o_bubble_cnt(a_cnt)
   );

   pipeline_controller #(.CWIDTH(2), .LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2)) u_sat (
      .hc_clk(clk), .hc_rst(rst_b),
      .hc_i_stall_f(i_f), .hc_i_stall_ds(i_ds), .hc_i_stall_ex(i_ex),
      .hc_i_stall_mem(i_mem), .hc_i_stall_wb(i_wb),
      .hc_i_ds_rs1(rs1), .hc_i_ds_rs2(rs2),
      .hc_i_ds_rs1_used(rs1_used), .hc_i_ds_rs2_used(rs2_used),
      .hc_i_ex_rd(ex_rd), .hc_i_ex_load(ex_load), .hc_i_ex_we(ex_we),
      .hc_i_change_pc(change_pc), .hc_i_alu_pc_value(alu_pc),
      .hc_o_stall_f(b_f), .hc_o_stall_ds(b_ds), .hc_o_stall_ex(b_ex),
      .hc_o_stall_mem(b_mem), .hc_o_stall_wb(b_wb),
      .hc_o_flush_ds(b_fds), .hc_o_flush_ex(b_fex),
      .hc_o_change_pc(b_cpc), .hc_o_pc_value(b_pc),
      .hc_o_busy(b_busy), .hc_o_bubble_cnt(b_cnt)
   );

   typedef struct {
      string       tag;
      logic [4:0]  st;
      logic        fds, fex, cpc, busy;
      logic [31:0] pc;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int npass = 0;
   int ntot  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic push(input string tag, input logic [4:0] st, input logic fds, input logic fex,
                       input logic cpc, input logic busy, input logic [31:0] pc, input logic [15:0] cnt);
      exp_t e;
      e.tag = tag; e.st = st; e.fds = fds; e.fex = fex;
      e.cpc = cpc; e.busy = busy; e.pc = pc; e.cnt = cnt;
      sb.push_back(e);
   endtask

   // Compare u_dut at the falling edge against the oldest queued expectation, then advance a cycle.
   task automatic settle();
      exp_t e;
      @(negedge clk);
      e = sb.pop_front();
      chk({e.tag, ".stall"}, 32'(a_st),   32'(e.st));
      chk({e.tag, ".fds"},   32'(a_fds),  32'(e.fds));
      chk({e.tag, ".fex"},   32'(a_fex),  32'(e.fex));
      chk({e.tag, ".cpc"},   32'(a_cpc),  32'(e.cpc));
      chk({e.tag, ".busy"},  32'(a_busy), 32'(e.busy));
      chk({e.tag, ".pc"},    a_pc,        e.pc);
      chk({e.tag, ".cnt"},   32'(a_cnt),  32'(e.cnt));
      @(posedge clk); #1;
   endtask

   task automatic b_check(input string tag, input logic [4:0] st, input logic fds, input logic fex,
                          input logic cpc, input logic busy, input logic [1:0] cnt);
      @(negedge clk);
      chk({tag, ".stall"}, 32'(b_st),   32'(st));
      chk({tag, ".fds"},   32'(b_fds),  32'(fds));
      chk({tag, ".fex"},   32'(b_fex),  32'(fex));
      chk({tag, ".cpc"},   32'(b_cpc),  32'(cpc));
      chk({tag, ".busy"},  32'(b_busy), 32'(busy));
      chk({tag, ".cnt"},   32'(b_cnt),  32'(cnt));
      @(posedge clk); #1;
   endtask

   task automatic clr_in();
      i_f = 0; i_ds = 0; i_ex = 0; i_mem = 0; i_wb = 0;
      rs1 = '0; rs2 = '0; ex_rd = '0;
      rs1_used = 0; rs2_used = 0; ex_load = 0; ex_we = 0;
      change_pc = 0; alu_pc = '0;
   endtask

   logic [1:0] ecnt;

   initial begin
      rst_a = 0; rst_b = 0;
      clr_in();
      @(posedge clk); @(posedge clk); #1;

      // Reset state, and stalls pass through while held in reset
      push("rst", 5'b00000, 0, 0, 0, 0, 32'h0, 16'd0); settle();
      i_mem = 1;
      push("rst_stall", 5'b11110, 0, 0, 0, 0, 32'h0, 16'd0); settle();
      rst_a = 1; clr_in();
      push("idle", 5'b00000, 0, 0, 0, 0, 32'h0, 16'd0); settle();

      i_mem = 1;
      push("stall_mem", 5'b11110, 0, 0, 0, 0, 32'h0, 16'd0); settle();
      clr_in(); i_wb = 1;
      push("stall_wb", 5'b11111, 0, 0, 0, 0, 32'h0, 16'd0); settle();
      clr_in(); i_f = 1;
      push("stall_f", 5'b10000, 0, 0, 0, 0, 32'h0, 16'd0); settle();

      // Load-use via rs2, single bubble
      clr_in(); ex_load = 1; ex_we = 1; ex_rd = 5'd5; rs2 = 5'd5; rs2_used = 1;
      push("lu_rs2", 5'b11000, 0, 1, 0, 0, 32'h0, 16'd0); settle();
      clr_in();
      push("lu_after", 5'b00000, 0, 0, 0, 0, 32'h0, 16'd1); settle();
      ex_load = 1; ex_we = 1; ex_rd = 5'd0; rs2 = 5'd0; rs2_used = 1;
      push("lu_rd0", 5'b00000, 0, 0, 0, 0, 32'h0, 16'd1); settle();
      clr_in(); ex_load = 1; ex_we = 1; ex_rd = 5'd7; rs1 = 5'd7; rs1_used = 0;
      push("lu_unused", 5'b00000, 0, 0, 0, 0, 32'h0, 16'd1); settle();
      ex_we = 0; rs1_used = 1;
      push("lu_nowe", 5'b00000, 0, 0, 0, 0, 32'h0, 16'd1); settle();
      ex_we = 1;
      push("lu_rs1", 5'b11000, 0, 1, 0, 0, 32'h0, 16'd1); settle();
      clr_in();
      push("lu_rs1_after", 5'b00000, 0, 0, 0, 0, 32'h0, 16'd2); settle();

      // Downstream stall suppresses lu in the detection cycle
      ex_load = 1; ex_we = 1; ex_rd = 5'd9; rs1 = 5'd9; rs1_used = 1; i_mem = 1;
      push("lu_gated", 5'b11110, 0, 0, 0, 0, 32'h0, 16'd2); settle();
      i_mem = 0;
      push("lu_ungated", 5'b11000, 0, 1, 0, 0, 32'h0, 16'd2); settle();
      clr_in();
      push("lu_gated_after", 5'b00000, 0, 0, 0, 0, 32'h0, 16'd3); settle();

      // Redirect to 0x40, with a second request during FLUSH that must be ignored
      change_pc = 1; alu_pc = 32'h40;
      push("rd_req", 5'b00000, 0, 0, 0, 0, 32'h0, 16'd3); settle();
      clr_in();
      push("rd_n1", 5'b00000, 1, 1, 1, 1, 32'h40, 16'd3); settle();
      change_pc = 1; alu_pc = 32'h80;
      push("rd_n2", 5'b00000, 1, 1, 0, 1, 32'h40, 16'd4); settle();
      clr_in();
      push("rd_n3", 5'b00000, 0, 0, 0, 0, 32'h40, 16'd5); settle();

      // Hazard and redirect together: redirect wins, no lu
      ex_load = 1; ex_we = 1; ex_rd = 5'd3; rs1 = 5'd3; rs1_used = 1;
      change_pc = 1; alu_pc = 32'h100;
      push("sim_req", 5'b00000, 0, 0, 0, 0, 32'h40, 16'd5); settle();
      clr_in();
      push("sim_n1", 5'b00000, 1, 1, 1, 1, 32'h100, 16'd5); settle();
      push("sim_n2", 5'b00000, 1, 1, 0, 1, 32'h100, 16'd6); settle();
      push("sim_n3", 5'b00000, 0, 0, 0, 0, 32'h100, 16'd7); settle();

      // Redirect held off by a writeback stall
      change_pc = 1; alu_pc = 32'h200; i_wb = 1;
      push("gate_1", 5'b11111, 0, 0, 0, 0, 32'h100, 16'd7); settle();
      push("gate_2", 5'b11111, 0, 0, 0, 0, 32'h100, 16'd7); settle();
      i_wb = 0;
      push("gate_rel", 5'b00000, 0, 0, 0, 0, 32'h100, 16'd7); settle();
      clr_in();
      push("gate_n1", 5'b00000, 1, 1, 1, 1, 32'h200, 16'd7); settle();
      push("gate_n2", 5'b00000, 1, 1, 0, 1, 32'h200, 16'd8); settle();
      push("gate_n3", 5'b00000, 0, 0, 0, 0, 32'h200, 16'd9); settle();

      // Second instance: two-cycle load stall, saturation, reset abort
      rst_a = 0; rst_b = 1;
      b_check("s_idle", 5'b00000, 0, 0, 0, 0, 2'd0);
      ex_load = 1; ex_we = 1; ex_rd = 5'd3; rs1 = 5'd3; rs1_used = 1;
      b_check("s_lu_n", 5'b11000, 0, 1, 0, 0, 2'd0);
      clr_in();
      b_check("s_lu_n1", 5'b11000, 0, 1, 0, 1, 2'd1);
      b_check("s_lu_done", 5'b00000, 0, 0, 0, 0, 2'd2);
      ecnt = 2'd2;
      for (int k = 0; k < 5; k++) begin
         change_pc = 1; alu_pc = 32'h1000 + 32'(k * 4);
         b_check("s_req", 5'b00000, 0, 0, 0, 0, ecnt);
         change_pc = 0;
         b_check("s_f1", 5'b00000, 1, 1, 1, 1, ecnt);
         ecnt = (ecnt == 2'd3) ? 2'd3 : ecnt + 2'd1;
         b_check("s_f2", 5'b00000, 1, 1, 0, 1, ecnt);
         ecnt = (ecnt == 2'd3) ? 2'd3 : ecnt + 2'd1;
      end
      b_check("s_sat", 5'b00000, 0, 0, 0, 0, 2'd3);

      change_pc = 1; alu_pc = 32'h2000;
      b_check("s_ab_req", 5'b00000, 0, 0, 0, 0, 2'd3);
      change_pc = 0;
      @(negedge clk);
      chk("s_ab_busy", 32'(b_busy), 32'd1);
      chk("s_ab_fds",  32'(b_fds),  32'd1);
      #2 rst_b = 0;
      #1;
      chk("s_ab_busy0", 32'(b_busy), 32'd0);
      chk("s_ab_fds0",  32'(b_fds),  32'd0);
      chk("s_ab_fex0",  32'(b_fex),  32'd0);
      chk("s_ab_cpc0",  32'(b_cpc),  32'd0);
      chk("s_ab_cnt0",  32'(b_cnt),  32'd0);
      chk("s_ab_pc0",   b_pc,        32'h0);
      @(posedge clk); #1;
      rst_b = 1;
      b_check("s_post1", 5'b00000, 0, 0, 0, 0, 2'd0);
      b_check("s_post2", 5'b00000, 0, 0, 0, 0, 2'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
